// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the uint8 systolic MAC processing element.
package sa_pkg;
  localparam int UINT8_W   = 8;
  localparam int ACC_W_DEF = 24;
  localparam int K_LEN_DEF = 9;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_t;
endpackage

// File: rtl/uint8_mac_acc.sv
// Window accumulator: beat counter, running sum and the IDLE/ACCUM FSM.
// Defining PE_SATURATE_EN clamps the running sum at its maximum instead of wrapping.
module uint8_mac_acc
  import sa_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int K_LEN = K_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [UINT8_W-1:0] a_in,
  input  logic [UINT8_W-1:0] w_in,
  input  logic               valid_in,
  input  logic               clear_in,
  output logic               done,
  output logic [ACC_W-1:0]   sum
);
  localparam logic [7:0] LAST_CNT = 8'(K_LEN - 1);

  pe_state_t              state;
  logic [7:0]             count;
  logic [ACC_W-1:0]       acc;
  logic [2*UINT8_W-1:0]   product;
  logic [ACC_W-1:0]       acc_base;
  logic [7:0]             count_base;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
`ifdef PE_SATURATE_EN
    logic [ACC_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
`else
    return x + y;
`endif
  endfunction

  assign product = 16'(a_in) * 16'(w_in);

  // A clear (or an idle FSM) makes the current beat the first of a fresh window.
  always_comb begin
    acc_base   = acc;
    count_base = count;
    if (clear_in || state == IDLE) begin
      acc_base   = '0;
      count_base = '0;
    end
  end

  assign sum  = acc_add(acc_base, ACC_W'(product));
  assign done = valid_in && (count_base == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else if (valid_in) begin
      if (done) begin
        state <= IDLE;
        acc   <= '0;
        count <= '0;
      end else begin
        state <= ACCUM;
        acc   <= sum;
        count <= count_base + 8'd1;
      end
    end else if (clear_in) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end
  end
endmodule

// File: rtl/uint8_mac_pe.sv
// uint8 systolic MAC PE: operand pass-through plus a one-deep result buffer with handshake.
// Optional build macro PE_SATURATE_EN (clamping accumulator, see uint8_mac_acc).
module uint8_mac_pe
  import sa_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int K_LEN = K_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [UINT8_W-1:0] a_in,
  input  logic [UINT8_W-1:0] w_in,
  input  logic               valid_in,
  input  logic               clear_in,
  output logic [UINT8_W-1:0] a_out,
  output logic [UINT8_W-1:0] w_out,
  output logic               valid_out,
  output logic [ACC_W-1:0]   res_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               ovf_out
);
  logic             done;
  logic [ACC_W-1:0] sum;

  uint8_mac_acc #(
    .ACC_W (ACC_W),
    .K_LEN (K_LEN)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .w_in     (w_in),
    .valid_in (valid_in),
    .clear_in (clear_in),
    .done     (done),
    .sum      (sum)
  );

  // Pass-through stage to east/south neighbours, never stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out     <= '0;
      w_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      a_out     <= a_in;
      w_out     <= w_in;
      valid_out <= valid_in;
    end
  end

  // Result stage: a new completion always wins; overwriting an unconsumed result is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_out   <= '0;
      res_valid <= 1'b0;
      ovf_out   <= 1'b0;
    end else if (done) begin
      res_out   <= sum;
      res_valid <= 1'b1;
      if (res_valid && !res_ready) ovf_out <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uint8_mac_pe.sv
// Self-checking bench for uint8_mac_pe: directed window cases on several parameter sets
// plus a randomized stream against a window-sum reference model.
module tb_uint8_mac_pe;
  logic       clk, rst, v, c, rdy;
  logic [7:0] a, w;

  logic [7:0]  o9_a, o9_w, o2_a, o2_w, o3_a, o3_w, o1_a, o1_w;
  logic        o9_v, o2_v, o3_v, o1_v;
  logic [23:0] o9_res, o3_res, o1_res;
  logic [15:0] o2_res;
  logic        o9_rv, o2_rv, o3_rv, o1_rv;
  logic        o9_ovf, o2_ovf, o3_ovf, o1_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  int unsigned win[$];
  logic [23:0] m_res;
  logic        m_rv, m_ovf;

  uint8_mac_pe #(.ACC_W(24), .K_LEN(9)) d9 (
    .clk(clk), .rst(rst), .a_in(a), .w_in(w), .valid_in(v), .clear_in(c),
    .a_out(o9_a), .w_out(o9_w), .valid_out(o9_v), .res_out(o9_res),
    .res_valid(o9_rv), .res_ready(rdy), .ovf_out(o9_ovf));
  uint8_mac_pe #(.ACC_W(16), .K_LEN(2)) d2 (
    .clk(clk), .rst(rst), .a_in(a), .w_in(w), .valid_in(v), .clear_in(c),
    .a_out(o2_a), .w_out(o2_w), .valid_out(o2_v), .res_out(o2_res),
    .res_valid(o2_rv), .res_ready(rdy), .ovf_out(o2_ovf));
  uint8_mac_pe #(.ACC_W(24), .K_LEN(3)) d3 (
    .clk(clk), .rst(rst), .a_in(a), .w_in(w), .valid_in(v), .clear_in(c),
    .a_out(o3_a), .w_out(o3_w), .valid_out(o3_v), .res_out(o3_res),
    .res_valid(o3_rv), .res_ready(rdy), .ovf_out(o3_ovf));
  uint8_mac_pe #(.ACC_W(24), .K_LEN(1)) d1 (
    .clk(clk), .rst(rst), .a_in(a), .w_in(w), .valid_in(v), .clear_in(c),
    .a_out(o1_a), .w_out(o1_w), .valid_out(o1_v), .res_out(o1_res),
    .res_valid(o1_rv), .res_ready(rdy), .ovf_out(o1_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    win.delete();
    m_res = '0;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Reference for the K_LEN=9 instance: collect products of the open window, sum when full.
  task automatic model_step(input logic pv, input logic pc, input logic [7:0] pa,
                            input logic [7:0] pw, input logic pr);
    int unsigned s;
    logic        fin;
    fin = 1'b0;
    s   = 0;
    if (pc) win.delete();
    if (pv) begin
      win.push_back(int'(pa) * int'(pw));
      if (win.size() == 9) begin
        foreach (win[i]) s += win[i];
        win.delete();
        fin = 1'b1;
      end
    end
    if (fin) begin
      if (m_rv && !pr) m_ovf = 1'b1;
      m_res = 24'(s);
      m_rv  = 1'b1;
    end else if (m_rv && pr) begin
      m_rv = 1'b0;
    end
  endtask

  task automatic cyc(input bit full_chk);
    logic [7:0] pa, pw;
    logic       pv, pc, pr;
    pa = a; pw = w; pv = v; pc = c; pr = rdy;
    @(posedge clk);
    #1;
    model_step(pv, pc, pa, pw, pr);
    if (full_chk) begin
      chk("a_out", {24'd0, o9_a}, {24'd0, pa});
      chk("w_out", {24'd0, o9_w}, {24'd0, pw});
      chk("valid_out", {31'd0, o9_v}, {31'd0, pv});
      chk("res_valid", {31'd0, o9_rv}, {31'd0, m_rv});
      chk("res_out", {8'd0, o9_res}, {8'd0, m_res});
      chk("ovf_out", {31'd0, o9_ovf}, {31'd0, m_ovf});
    end
  endtask

  task automatic drive(input logic nv, input logic nc, input logic [7:0] na,
                       input logic [7:0] nw);
    v = nv; c = nc; a = na; w = nw;
    cyc(1'b0);
  endtask

  task automatic do_reset();
    v = 0; c = 0; a = 0; w = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_a_out", {24'd0, o9_a}, 32'd0);
    chk("rst_valid_out", {31'd0, o9_v}, 32'd0);
    chk("rst_res_out", {8'd0, o9_res}, 32'd0);
    chk("rst_res_valid", {31'd0, o9_rv}, 32'd0);
    chk("rst_ovf", {31'd0, o1_ovf}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; v = 0; c = 0; rdy = 0; a = 0; w = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_w_out", {24'd0, o9_w}, 32'd0);
    chk("init_res_out", {8'd0, o9_res}, 32'd0);
    chk("init_res_valid", {31'd0, o9_rv}, 32'd0);
    chk("init_ovf", {31'd0, o9_ovf}, 32'd0);
    rst = 1'b0;

    // Nine beats of 2*3 on the K_LEN=9 instance.
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'd2, 8'd3);
      chk("k9_early_valid", {31'd0, o9_rv}, 32'd0);
    end
    drive(1, 0, 8'd2, 8'd3);
    chk("k9_res", {8'd0, o9_res}, 32'd54);
    chk("k9_res_valid", {31'd0, o9_rv}, 32'd1);
    drive(0, 0, 8'd0, 8'd0);
    chk("k9_res_valid_drop", {31'd0, o9_rv}, 32'd0);
    chk("k9_res_hold", {8'd0, o9_res}, 32'd54);

    // 16-bit accumulator, two beats of 255*255.
    do_reset();
    drive(1, 0, 8'd255, 8'd255);
    drive(1, 0, 8'd255, 8'd255);
`ifdef PE_SATURATE_EN
    chk("k2_sat_res", {16'd0, o2_res}, 32'd65535);
`else
    chk("k2_wrap_res", {16'd0, o2_res}, 32'd64514);
`endif
    chk("k2_res_valid", {31'd0, o2_rv}, 32'd1);

    // Clear with a beat restarts the K_LEN=3 window.
    do_reset();
    drive(1, 0, 8'd1, 8'd1);
    drive(1, 0, 8'd2, 8'd2);
    drive(1, 1, 8'd3, 8'd3);
    chk("k3_no_abort_res", {31'd0, o3_rv}, 32'd0);
    drive(1, 0, 8'd4, 8'd4);
    chk("k3_no_early_res", {31'd0, o3_rv}, 32'd0);
    drive(1, 0, 8'd5, 8'd5);
    chk("k3_res", {8'd0, o3_res}, 32'd50);
    chk("k3_res_valid", {31'd0, o3_rv}, 32'd1);

    // K_LEN=1 overwrite, clear isolation and handshake.
    do_reset();
    rdy = 1'b0;
    drive(1, 0, 8'd7, 8'd7);
    chk("k1_first_res", {8'd0, o1_res}, 32'd49);
    chk("k1_first_ovf", {31'd0, o1_ovf}, 32'd0);
    drive(1, 0, 8'd8, 8'd8);
    chk("k1_over_res", {8'd0, o1_res}, 32'd64);
    chk("k1_over_valid", {31'd0, o1_rv}, 32'd1);
    chk("k1_over_ovf", {31'd0, o1_ovf}, 32'd1);
    drive(0, 1, 8'd0, 8'd0);
    chk("k1_clear_keeps_valid", {31'd0, o1_rv}, 32'd1);
    chk("k1_clear_keeps_res", {8'd0, o1_res}, 32'd64);
    rdy = 1'b1;
    drive(0, 0, 8'd0, 8'd0);
    chk("k1_accept_valid", {31'd0, o1_rv}, 32'd0);
    chk("k1_sticky_ovf", {31'd0, o1_ovf}, 32'd1);
    chk("k1_accept_res_hold", {8'd0, o1_res}, 32'd64);
    do_reset();
    drive(1, 0, 8'd2, 8'd2);
    drive(1, 0, 8'd3, 8'd3);
    chk("k1_same_cycle_res", {8'd0, o1_res}, 32'd9);
    chk("k1_same_cycle_valid", {31'd0, o1_rv}, 32'd1);
    chk("k1_same_cycle_ovf", {31'd0, o1_ovf}, 32'd0);

    // Random stream on the K_LEN=9 instance with a reset dropped mid-window.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom % 10) < 7;
      c   = ($urandom % 40) == 0;
      rdy = $urandom % 2;
      a   = 8'($urandom);
      w   = 8'($urandom);
      cyc(1'b1);
      if (i == 300) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
